// File: rtl/d_ff_sync_debounce_if.sv
// Level-path bundle for d_ff_sync_debounce: raw input in, debounced level and edge pulses out.
// Optional macro DSD_QB_EN adds the inverted level qb.
interface d_ff_sync_debounce_if;

  logic d_raw;
  logic q;
  logic rise;
  logic fall;
`ifdef DSD_QB_EN
  logic qb;
`endif

  // Driver side: owns the raw level, observes the cleaned outputs.
  modport master (
    output d_raw,
    input  q,
    input  rise,
`ifdef DSD_QB_EN
    input  qb,
`endif
    input  fall
  );

  // Debouncer side.
  modport slave (
    input  d_raw,
    output q,
    output rise,
`ifdef DSD_QB_EN
    output qb,
`endif
    output fall
  );

endinterface : d_ff_sync_debounce_if

// File: rtl/d_ff_sync_debounce.sv
// Synchroniser plus stability-counter debouncer that produces a clock-aligned level
// for the d_ff d input, with one-cycle rise/fall pulses on each accepted transition.
// Optional macro DSD_QB_EN: exposes qb = ~q on the interface.
module d_ff_sync_debounce #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  d_ff_sync_debounce_if.slave    bus
);

  // Terminal count: the edge on which a still-differing input is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  state_e                 state_q;
  state_e                 state_d;
  logic                   q_q;
  logic                   q_d;
  logic                   rise_q;
  logic                   rise_d;
  logic                   fall_q;
  logic                   fall_d;
  logic                   s_c;
  logic                   accept_c;

  // Synchroniser shift chain: newest sample enters at bit 0.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], bus.d_raw};
  assign s_c    = sync_q[SYNC_STAGES-1];

  // Synchroniser flops, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  // FSM state, stability counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Next state: count consecutive edges where s differs from q; a match drops the glitch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    q_d      = q_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    accept_c = 1'b0;

    case (state_q)
      ST_STABLE: begin
        if (s_c != q_q) begin
          if (STABLE_CYCLES == 1) begin
            accept_c = 1'b1;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (s_c == q_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          accept_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase

    // Accept: q takes the synchronised level and the matching edge pulse is raised.
    if (accept_c) begin
      q_d     = s_c;
      rise_d  = s_c;
      fall_d  = ~s_c;
      cnt_d   = '0;
      state_d = ST_STABLE;
    end
  end

  assign bus.q    = q_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

`ifdef DSD_QB_EN
  // Inverted level; reads 1 whenever q has been reset to 0.
  assign bus.qb = ~q_q;
`endif

endmodule : d_ff_sync_debounce
